// File: rtl/mdu_ctrl_pkg.sv
// Shared decode constants and types for the HI/LO
// multiply/divide sequencer.
package mdu_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic is_start;
    logic is_signed;
    logic is_div;
    logic is_mf;
    logic is_mt;
    logic sel_hi;
  } md_cls_t;

  function automatic logic [5:0] op_of(
    input logic [31:0] ir
  );
    return ir[31:26];
  endfunction

  function automatic logic [5:0] fn_of(
    input logic [31:0] ir
  );
    return ir[5:0];
  endfunction

endpackage

// File: rtl/mdu_ctrl_md_decode.sv
// Combinational classifier for the eight HI/LO
// instructions; used for both the D and E stages.
module md_decode
  import mdu_ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output md_cls_t     cls_o
);

  logic [5:0] fn;
  logic       spc;
  logic       unused_ir;

  assign fn        = fn_of(ir_i);
  assign spc       = (op_of(ir_i) == OP_SPECIAL);
  assign unused_ir = ^ir_i[25:6];

  // Classify by funct field within SPECIAL opcode
  always_comb begin
    cls_o = '0;
    if (spc) begin
      unique case (1'b1)
        fn == FN_MULT: begin
          cls_o.is_start  = 1'b1;
          cls_o.is_signed = 1'b1;
        end
        fn == FN_MULTU: begin
          cls_o.is_start  = 1'b1;
        end
        fn == FN_DIV: begin
          cls_o.is_start  = 1'b1;
          cls_o.is_signed = 1'b1;
          cls_o.is_div    = 1'b1;
        end
        fn == FN_DIVU: begin
          cls_o.is_start  = 1'b1;
          cls_o.is_div    = 1'b1;
        end
        fn == FN_MFHI: begin
          cls_o.is_mf  = 1'b1;
          cls_o.sel_hi = 1'b1;
        end
        fn == FN_MFLO: begin
          cls_o.is_mf  = 1'b1;
        end
        fn == FN_MTHI: begin
          cls_o.is_mt  = 1'b1;
          cls_o.sel_hi = 1'b1;
        end
        fn == FN_MTLO: begin
          cls_o.is_mt  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide sequencer: starts ops from E,
// counts fixed latency, commits HI/LO, stalls D.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir_d,
  input  logic [31:0] ir_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  output logic [31:0] md_rdata,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        stall_md
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  md_cls_t cls_d;
  md_cls_t cls_e;

  md_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] pend_hi_q;
  logic [31:0] pend_lo_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [63:0]   res_d;
  logic [CW-1:0] cnt_d;
  logic          hilo_d;
  logic          unused_cls;

  md_decode u_dec_d (
    .ir_i  (ir_d),
    .cls_o (cls_d)
  );

  md_decode u_dec_e (
    .ir_i  (ir_e),
    .cls_o (cls_e)
  );

  assign unused_cls = cls_d.is_signed
                    ^ cls_d.is_div
                    ^ cls_d.sel_hi;

  // 64-bit result of the op in E; divide uses
  // magnitudes so MIN/-1 wraps to MIN naturally
  always_comb begin
    logic [63:0] ea;
    logic [63:0] eb;
    logic [31:0] aa;
    logic [31:0] ab;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        na;
    logic        nb;
    na = cls_e.is_signed & rs_e[31];
    nb = cls_e.is_signed & rt_e[31];
    ea = {{32{na}}, rs_e};
    eb = {{32{nb}}, rt_e};
    aa = na ? (32'd0 - rs_e) : rs_e;
    ab = nb ? (32'd0 - rt_e) : rt_e;
    uq = '0;
    ur = '0;
    if (ab != '0) begin
      uq = aa / ab;
      ur = aa % ab;
    end
    res_d = ea * eb;
    if (cls_e.is_div) begin
      if (rt_e == '0) begin
        res_d = {hi_q, lo_q};
      end else begin
        res_d[31:0]  = (na ^ nb) ?
                       (32'd0 - uq) : uq;
        res_d[63:32] = na ?
                       (32'd0 - ur) : ur;
      end
    end
  end

  assign cnt_d = cls_e.is_div ?
                 CW'(DIV_CYCLES) :
                 CW'(MULT_CYCLES);

  // Sequencer: launch, count down, commit HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cls_e.is_start) begin
            pend_hi_q <= res_d[63:32];
            pend_lo_q <= res_d[31:0];
            cnt_q     <= cnt_d;
            state_q   <= S_BUSY;
          end else if (cls_e.is_mt) begin
            if (cls_e.sel_hi) hi_q <= rs_e;
            else              lo_q <= rs_e;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // mfhi/mflo read architectural HI/LO only
  always_comb begin
    md_rdata = '0;
    if (cls_e.is_mf) begin
      md_rdata = cls_e.sel_hi ? hi_q : lo_q;
    end
  end

  assign hilo_d   = cls_d.is_start
                  | cls_d.is_mf
                  | cls_d.is_mt;
  assign busy     = (state_q == S_BUSY);
  assign stall_md = hilo_d
                  & (busy | cls_e.is_start);
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule
